// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling feeding a first-word-fall-through byte FIFO.
// Framing and overrun errors are kept as sticky flags until err_clr.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          rx,
  output logic [7:0]                    dout,
  output logic                          rdy,
  input  logic                          rdy_clr,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          overrun,
  input  logic                          err_clr
);

  localparam int DIV = CLK_FREQ / (BAUD * 16);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic          rx_meta_q, rx_s_q;
  state_e        state_q;
  logic [TW-1:0] tcnt_q;
  logic [3:0]    sc_q;
  logic [2:0]    bi_q;
  logic [7:0]    shreg_q;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          frame_err_q, overrun_q;

  logic tick, stop_tick, stop_ok, stop_bad, pop, push, ovr_evt;

  assign tick      = (tcnt_q == TICK_LAST);
  assign stop_tick = (state_q == S_STOP) && tick && (sc_q == 4'd15);
  assign stop_ok   = stop_tick && rx_s_q;
  assign stop_bad  = stop_tick && !rx_s_q;
  assign pop       = rdy_clr && rdy;
  assign push      = stop_ok && ((count_q != FULL) || pop);
  assign ovr_evt   = stop_ok && (count_q == FULL) && !pop;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // The tick counter restarts on the start edge so every sample lands mid-bit.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
      tcnt_q  <= '0;
      sc_q    <= '0;
      bi_q    <= '0;
      shreg_q <= '0;
    end else begin
      tcnt_q <= tick ? '0 : tcnt_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_q <= S_START;
            sc_q    <= '0;
            tcnt_q  <= '0;
          end
        end
        S_START: begin
          if (tick) begin
            if (sc_q == 4'd7) begin
              sc_q <= '0;
              bi_q <= '0;
              state_q <= rx_s_q ? S_IDLE : S_DATA;
            end else begin
              sc_q <= sc_q + 4'd1;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            if (sc_q == 4'd15) begin
              sc_q          <= '0;
              shreg_q[bi_q] <= rx_s_q;
              if (bi_q == 3'd7) state_q <= S_STOP;
              else              bi_q    <= bi_q + 3'd1;
            end else begin
              sc_q <= sc_q + 4'd1;
            end
          end
        end
        S_STOP: begin
          if (tick) begin
            if (sc_q == 4'd15) begin
              sc_q    <= '0;
              state_q <= S_IDLE;
            end else begin
              sc_q <= sc_q + 4'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr_q] <= shreg_q;
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Error events take priority over a coincident clear.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      if (stop_bad)     frame_err_q <= 1'b1;
      else if (err_clr) frame_err_q <= 1'b0;
      if (ovr_evt)      overrun_q <= 1'b1;
      else if (err_clr) overrun_q <= 1'b0;
    end
  end

  assign rdy       = (count_q != '0);
  assign dout      = rdy ? mem[rd_ptr_q] : 8'h00;
  assign count     = count_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
